fp_class_pipe: RTL and testbench
================================

FP_CLASS_PIPE -- requirements
Module: fp_class_pipe

Interface
REQ-001 The module SHALL have parameter SIGN_W, default 1, sign field width.
REQ-002 The module SHALL have parameter EXPO_W, default 8, exponent field width.
REQ-003 The module SHALL have parameter MANT_W, default 23, mantissa field width; MANT_W >= 2.
REQ-004 The module SHALL have parameter LANES, default 4, operands per beat.
REQ-005 The module SHALL have parameter CNT_W, default 16, zero-event counter width.
REQ-006 The module SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-007 The module SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 The module SHALL have port in_valid  input  1  input beat valid.
REQ-009 The module SHALL have port in_ready  output  1  input beat accepted when in_valid & in_ready.
REQ-010 The module SHALL have port in_sign  input  LANES*SIGN_W  per-lane sign, lane i at [i*SIGN_W +: SIGN_W].
REQ-011 The module SHALL have port in_expo  input  LANES*EXPO_W  per-lane exponent, same packing.
REQ-012 The module SHALL have port in_mant  input  LANES*MANT_W  per-lane mantissa, same packing.
REQ-013 The module SHALL have port out_valid  output  1  result beat valid.
REQ-014 The module SHALL have port out_ready  input  1  downstream accepts result.
REQ-015 The module SHALL have port out_class  output  LANES*3  per-lane class code.
REQ-016 The module SHALL have port out_mant_zero  output  LANES  per-lane flag, mantissa all zeros.
REQ-017 The module SHALL have port cnt_clr  input  1  synchronous clear of zero_cnt.
REQ-018 The module SHALL have port zero_cnt  output  CNT_W  saturating count of ZERO-class lanes delivered.

Function
REQ-019 Class codes SHALL be: ZERO=0, SUBN=1, NORM=2, INF=3, QNAN=4, SNAN=5; 6,7 never produced.
REQ-020 Per lane: expo all-0 & mant all-0 -> ZERO; expo all-0 & mant nonzero -> SUBN; expo all-1 & mant all-0 -> INF; expo all-1 & mant MSB=1 -> QNAN; expo all-1 & mant MSB=0 & mant nonzero -> SNAN; else NORM; sign SHALL NOT affect class.
REQ-021 out_mant_zero[i] SHALL equal (mant_i == 0) regardless of exponent.
REQ-022 Pipeline SHALL be two register stages (S1 operand capture, S2 class result); latency 2 cycles from accepted input to out_valid with out_ready held high.
REQ-023 S2 accepts when ~s2_valid | out_ready; S1 accepts when ~s1_valid | S2-accept; in_ready = S1-accept (combinational path out_ready -> in_ready permitted).
REQ-024 Sustained throughput SHALL be one beat per cycle when out_ready is high.
REQ-025 While out_valid & ~out_ready, out_class and out_mant_zero SHALL hold stable; no beat SHALL be dropped or duplicated.
REQ-026 On each out_valid & out_ready, zero_cnt SHALL increase by the number of lanes with class ZERO, saturating at 2^CNT_W-1.
REQ-027 cnt_clr SHALL set zero_cnt to 0 next cycle; clear SHALL win over a same-cycle increment, that increment discarded.
REQ-028 in_ready is unconstrained while in_valid is low; input data is ignored when in_valid is low.

Reset
REQ-029 rst SHALL clear s1_valid, s2_valid and zero_cnt; out_valid=0, in_ready=1 the cycle after reset, out_class=0, out_mant_zero=0.
REQ-030 Reset mid-operation SHALL discard all in-flight beats without emitting them.

Structure
REQ-031 Package fp_class_pkg SHALL hold the 3-bit class enum fp_class_e and its code constants.
REQ-032 Sub-module fp_class_lane (combinational, one lane: expo, mant -> class, mant_zero) SHALL be instantiated LANES times in S2 input logic.

Verification
REQ-033 Default params, out_ready=1, lanes {0x00/0x000000, 0x00/0x000001, 0x7F/0x400000, 0xFF/0x000000} -> out_class {0,1,2,3}, out_mant_zero {1,0,0,1}, exactly 2 cycles after accept; zero_cnt=1.
REQ-034 Lanes {0xFF/0x400000, 0xFF/0x000001, 0xFF/0x7FFFFF, sign=1 0x00/0} -> classes {4,5,4,0}.
REQ-035 Stream 10 back-to-back beats, out_ready low cycles 3-6 -> in_ready low once S1,S2 full, all 10 results in order, none lost, outputs stable while stalled.
REQ-036 CNT_W=4, 5 beats of 4 ZERO lanes -> zero_cnt 4,8,12,15,15.
REQ-037 cnt_clr asserted in same cycle as a handshake of 4 ZERO lanes with zero_cnt=7 -> zero_cnt=0 next cycle.
REQ-038 rst asserted with both stages valid -> out_valid=0 next cycle, no stale beat emitted afterwards, zero_cnt=0.

Source files
------------

// File: rtl/fp_class_pkg.sv
// Shared class encoding for the floating-point classification pipeline.
package fp_class_pkg;

    localparam int unsigned CLASS_W = 3;

    typedef enum logic [CLASS_W-1:0] {
        CLS_ZERO = 3'd0,
        CLS_SUBN = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_QNAN = 3'd4,
        CLS_SNAN = 3'd5
    } fp_class_e;

endpackage

// File: rtl/fp_class_lane.sv
// Single-lane combinational classifier: exponent/mantissa -> class code and mantissa-zero flag.
module fp_class_lane
    import fp_class_pkg::*;
#(
    parameter int unsigned EXPO_W = 8,
    parameter int unsigned MANT_W = 23
) (
    input  logic [EXPO_W-1:0] expo_i,
    input  logic [MANT_W-1:0] mant_i,
    output fp_class_e         class_o,
    output logic              mant_zero_o
);

    logic mant_is_zero;

    assign mant_is_zero = (mant_i == '0);
    assign mant_zero_o  = mant_is_zero;

    always_comb begin
        class_o = CLS_NORM;
        if (expo_i == '0) begin
            class_o = mant_is_zero ? CLS_ZERO : CLS_SUBN;
        end else if (expo_i == '1) begin
            // Mantissa MSB is the quiet bit; a clear MSB with any payload is signalling.
            if (mant_is_zero) begin
                class_o = CLS_INF;
            end else if (mant_i[MANT_W-1]) begin
                class_o = CLS_QNAN;
            end else begin
                class_o = CLS_SNAN;
            end
        end
    end

endmodule

// File: rtl/fp_class_pipe.sv
// Two-stage valid/ready pipeline classifying LANES operands per beat, with a
// saturating count of ZERO-class lanes delivered downstream.
module fp_class_pipe
    import fp_class_pkg::*;
#(
    parameter int unsigned SIGN_W = 1,
    parameter int unsigned EXPO_W = 8,
    parameter int unsigned MANT_W = 23,
    parameter int unsigned LANES  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*SIGN_W-1:0]    in_sign,
    input  logic [LANES*EXPO_W-1:0]    in_expo,
    input  logic [LANES*MANT_W-1:0]    in_mant,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*CLASS_W-1:0]   out_class,
    output logic [LANES-1:0]           out_mant_zero,
    input  logic                       cnt_clr,
    output logic [CNT_W-1:0]           zero_cnt
);

    localparam int unsigned LW    = $clog2(LANES + 1);
    localparam int unsigned SUM_W = ((CNT_W > LW) ? CNT_W : LW) + 1;

    logic                     s1_valid_q, s1_valid_d;
    logic [LANES*EXPO_W-1:0]  s1_expo_q, s1_expo_d;
    logic [LANES*MANT_W-1:0]  s1_mant_q, s1_mant_d;
    logic                     s2_valid_q, s2_valid_d;
    logic [LANES*CLASS_W-1:0] s2_class_q, s2_class_d;
    logic [LANES-1:0]         s2_mz_q, s2_mz_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic                     s1_accept, s2_accept;
    fp_class_e                lane_class [LANES];
    logic [LANES-1:0]         lane_mz;
    logic [LW-1:0]            zero_lanes;
    logic [SUM_W-1:0]         cnt_sum;

    // Sign never influences the class.
    logic                     sign_unused;
    assign sign_unused = ^in_sign;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fp_class_lane #(
            .EXPO_W (EXPO_W),
            .MANT_W (MANT_W)
        ) u_lane (
            .expo_i      (s1_expo_q[g*EXPO_W +: EXPO_W]),
            .mant_i      (s1_mant_q[g*MANT_W +: MANT_W]),
            .class_o     (lane_class[g]),
            .mant_zero_o (lane_mz[g])
        );
    end

    assign s2_accept = ~s2_valid_q | out_ready;
    assign s1_accept = ~s1_valid_q | s2_accept;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_expo_d  = s1_expo_q;
        s1_mant_d  = s1_mant_q;
        s2_valid_d = s2_valid_q;
        s2_class_d = s2_class_q;
        s2_mz_d    = s2_mz_q;

        if (s1_accept) begin
            s1_valid_d = in_valid;
        end
        if (s1_accept && in_valid) begin
            s1_expo_d = in_expo;
            s1_mant_d = in_mant;
        end

        if (s2_accept) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_accept && s1_valid_q) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                s2_class_d[i*CLASS_W +: CLASS_W] = lane_class[i];
            end
            s2_mz_d = lane_mz;
        end
    end

    always_comb begin
        zero_lanes = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (s2_class_q[i*CLASS_W +: CLASS_W] == CLS_ZERO) begin
                zero_lanes = zero_lanes + LW'(1);
            end
        end

        cnt_sum = SUM_W'(cnt_q) + SUM_W'(zero_lanes);
        cnt_d   = cnt_q;
        // Clear takes priority; the coincident increment is dropped.
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (s2_valid_q && out_ready) begin
            if (cnt_sum[SUM_W-1:CNT_W] != '0) begin
                cnt_d = '1;
            end else begin
                cnt_d = cnt_sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_expo_q  <= '0;
            s1_mant_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_class_q <= '0;
            s2_mz_q    <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_expo_q  <= s1_expo_d;
            s1_mant_q  <= s1_mant_d;
            s2_valid_q <= s2_valid_d;
            s2_class_q <= s2_class_d;
            s2_mz_q    <= s2_mz_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready      = s1_accept;
    assign out_valid     = s2_valid_q;
    assign out_class     = s2_class_q;
    assign out_mant_zero = s2_mz_q;
    assign zero_cnt      = cnt_q;

endmodule

// File: tb/tb_fp_class_pipe.sv
// Directed bench for fp_class_pipe: scoreboard of expected beats, stall and reset scenarios.
module tb_fp_class_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic         cnt_clr;
    logic [3:0]   in_sign;
    logic [31:0]  in_expo;
    logic [91:0]  in_mant;

    logic         in_ready, out_valid;
    logic [11:0]  out_class;
    logic [3:0]   out_mz;
    logic [15:0]  zero_cnt;

    logic         in_ready4, out_valid4;
    logic [11:0]  out_class4;
    logic [3:0]   out_mz4;
    logic [3:0]   zero_cnt4;

    fp_class_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_expo(in_expo), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_mant_zero(out_mz), .cnt_clr(cnt_clr), .zero_cnt(zero_cnt)
    );

    fp_class_pipe #(.CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_sign(in_sign), .in_expo(in_expo), .in_mant(in_mant),
        .out_valid(out_valid4), .out_ready(out_ready), .out_class(out_class4),
        .out_mant_zero(out_mz4), .cnt_clr(cnt_clr), .zero_cnt(zero_cnt4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] cls;
        logic [3:0]  mz;
    } beat_t;

    beat_t       sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_out = 0;
    logic        saw_stall = 1'b0;
    logic        held = 1'b0;
    logic [11:0] held_cls;
    logic [3:0]  held_mz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] mdl(input logic [7:0] e, input logic [22:0] m);
        if (e == 8'h00)      return (m == 23'h0) ? 3'd0 : 3'd1;
        else if (e == 8'hFF) return (m == 23'h0) ? 3'd3 : (m[22] ? 3'd4 : 3'd5);
        else                 return 3'd2;
    endfunction

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    always @(negedge clk) begin
        beat_t e;
        if (in_valid && !in_ready) saw_stall = 1'b1;
        if (held) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_class", {20'd0, out_class}, {20'd0, held_cls});
            chk("stall_mz", {28'd0, out_mz}, {28'd0, held_mz});
        end
        held = 1'b0;
        if (!rst && out_valid === 1'b1 && !out_ready) begin
            held     = 1'b1;
            held_cls = out_class;
            held_mz  = out_mz;
        end
        if (!rst && out_valid === 1'b1 && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", {31'd0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_class", {20'd0, out_class}, {20'd0, e.cls});
                chk("out_mant_zero", {28'd0, out_mz}, {28'd0, e.mz});
                chk("c4_out_class", {20'd0, out_class4}, {20'd0, e.cls});
                n_out++;
            end
        end
    end

    task automatic send(input logic [3:0] s, input logic [3:0][7:0] e, input logic [3:0][22:0] m,
                        input logic [11:0] ecls, input logic [3:0] emz);
        int unsigned w = 0;
        in_valid = 1'b1;
        in_sign  = s;
        in_expo  = e;
        in_mant  = m;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
        else sb.push_back({ecls, emz});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_expo  = $urandom;
        in_mant  = {$urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        int unsigned w = 0;
        @(negedge clk);
        while ((sb.size() != 0 || out_valid) && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("drain_empty", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][7:0]  se;
        logic [3:0][22:0] sm;
        logic [11:0]      scls;
        logic [3:0]       smz;
        int unsigned      exp4[5];
        int               base;

        exp4 = '{4, 8, 12, 15, 15};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        in_sign = '0; in_expo = '0; in_mant = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_class", {20'd0, out_class}, 32'd0);
        chk("rst_mz", {28'd0, out_mz}, 32'd0);
        chk("rst_zero_cnt", {16'd0, zero_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic classes and 2-cycle latency.
        send(4'b0000, {8'hFF, 8'h7F, 8'h00, 8'h00}, {23'h0, 23'h400000, 23'h1, 23'h0},
             {3'd3, 3'd2, 3'd1, 3'd0}, 4'b1001);
        idle();
        @(negedge clk);
        chk("lat1_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat2_out_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        chk("cnt_after_a", {16'd0, zero_cnt}, 32'd1);
        chk("cnt4_after_a", {28'd0, zero_cnt4}, 32'd1);
        @(posedge clk); #1;

        // NaN flavours, sign ignored.
        send(4'b1000, {8'h00, 8'hFF, 8'hFF, 8'hFF}, {23'h0, 23'h7FFFFF, 23'h1, 23'h400000},
             {3'd0, 3'd4, 3'd5, 3'd4}, 4'b1000);
        idle();
        drain();
        chk("cnt_after_b", {16'd0, zero_cnt}, 32'd2);

        // Back-to-back stream with a downstream stall.
        base = n_out;
        saw_stall = 1'b0;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    for (int l = 0; l < 4; l++) begin
                        case ($urandom_range(0, 3))
                            0:       se[l] = 8'h00;
                            1:       se[l] = 8'hFF;
                            default: se[l] = 8'($urandom_range(1, 254));
                        endcase
                        case ($urandom_range(0, 3))
                            0:       sm[l] = 23'h0;
                            1:       sm[l] = 23'h400000 | 23'($urandom);
                            2:       sm[l] = 23'h3FFFFF & 23'($urandom);
                            default: sm[l] = 23'($urandom);
                        endcase
                        scls[l*3 +: 3] = mdl(se[l], sm[l]);
                        smz[l] = (sm[l] == 23'h0);
                    end
                    send(4'($urandom), se, sm, scls, smz);
                end
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", n_out - base, 32'd10);
        chk("stream_in_ready_low", {31'd0, saw_stall}, 32'd1);

        // Saturation with a 4-bit counter.
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr_cnt4", {28'd0, zero_cnt4}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            send(4'($urandom), '0, '0, 12'h000, 4'hF);
            idle();
            repeat (3) @(negedge clk);
            chk("sat_cnt4", {28'd0, zero_cnt4}, exp4[k]);
            chk("sat_cnt16", {16'd0, zero_cnt}, 32'(4 * (k + 1)));
            @(posedge clk); #1;
        end

        // Clear coinciding with a 4-zero-lane handshake.
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        send(4'b0000, {8'h80, 8'h00, 8'h00, 8'h00}, '0, {3'd2, 9'd0}, 4'b1111);
        send(4'b0000, '0, '0, 12'h000, 4'hF);
        idle();
        drain();
        chk("pre_clr_cnt", {16'd0, zero_cnt}, 32'd7);
        send(4'b0000, '0, '0, 12'h000, 4'hF);
        idle();
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(negedge clk);
        chk("clr_hs_valid", {31'd0, out_valid}, 32'd1);
        chk("clr_hs_cnt", {16'd0, zero_cnt}, 32'd7);
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr_wins_cnt", {16'd0, zero_cnt}, 32'd0);
        chk("clr_wins_cnt4", {28'd0, zero_cnt4}, 32'd0);
        @(posedge clk); #1;
        chk("clr_stays_cnt", {16'd0, zero_cnt}, 32'd0);

        // Reset with both stages full.
        send(4'b0000, '0, '0, 12'h000, 4'hF);
        idle();
        drain();
        chk("pre_rst_cnt", {16'd0, zero_cnt}, 32'd4);
        out_ready = 1'b0;
        send(4'b0000, '0, '0, 12'h000, 4'hF);
        send(4'b0000, {8'h01, 8'h01, 8'h01, 8'h01}, '0, {3'd2, 3'd2, 3'd2, 3'd2}, 4'hF);
        idle();
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_cnt", {16'd0, zero_cnt}, 32'd0);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_class", {20'd0, out_class}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_quiet", {31'd0, out_valid}, 32'd0);
        end
        chk("post_rst_cnt_hold", {16'd0, zero_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
